// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state, opcode, funct and ALU control encodings for the MIPS controllers
package mips_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;
endpackage

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: maps (aluop, funct) to the 3-bit ALU control word
module mc_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);
  // Only aluop 10 consults funct; unknown functs fall back to add rather than trapping.
  always_comb begin
    alucontrol = aluop == ALUOP_SUB   ? ALUCTL_SUB :
                 aluop != ALUOP_FUNCT ? ALUCTL_ADD :
                 funct == FN_SUB      ? ALUCTL_SUB :
                 funct == FN_AND      ? ALUCTL_AND :
                 funct == FN_OR       ? ALUCTL_OR  :
                 funct == FN_SLT      ? ALUCTL_SLT : ALUCTL_ADD;
  end
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS main controller (Moore FSM plus ALU decode)
module mc_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               pcen,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic               illegal_op,
  output logic [STATE_W-1:0] dbg_state
);
  state_t state, state_nxt;
  logic pcwrite, branch, legal;
  logic [1:0] aluop;
  // State register; reset lands in FETCH at once, even mid-instruction.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= FETCH;
    else          state <= state_nxt;
  // Next state and Moore outputs per state; everything defaults to inactive.
  always_comb begin
    state_nxt = FETCH;
    pcwrite   = 1'b0;
    branch    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    iord      = 1'b0;
    memtoreg  = 1'b0;
    regdst    = 1'b0;
    pcsrc     = 2'b00;
    aluop     = ALUOP_ADD;
    case (state)
      FETCH:    begin alusrcb = 2'b01; irwrite = 1'b1; pcwrite = 1'b1; state_nxt = DECODE; end
      DECODE:   begin
        alusrcb   = 2'b11;
        state_nxt = (op == OP_LW || op == OP_SW) ? MEMADR   :
                    op == OP_RTYPE               ? EXECUTE  :
                    op == OP_BEQ                 ? BRANCH   :
                    op == OP_ADDI                ? ADDIEXEC :
                    op == OP_J                   ? JUMP     : FETCH;
      end
      MEMADR:   begin alusrca = 1'b1; alusrcb = 2'b10; state_nxt = op == OP_LW ? MEMRD : MEMWR; end
      MEMRD:    begin iord = 1'b1; state_nxt = MEMWB; end
      MEMWB:    begin regwrite = 1'b1; memtoreg = 1'b1; end
      MEMWR:    begin iord = 1'b1; memwrite = 1'b1; end
      EXECUTE:  begin alusrca = 1'b1; aluop = ALUOP_FUNCT; state_nxt = ALUWB; end
      ALUWB:    begin regdst = 1'b1; regwrite = 1'b1; end
      BRANCH:   begin alusrca = 1'b1; aluop = ALUOP_SUB; pcsrc = 2'b01; branch = 1'b1; end
      ADDIEXEC: begin alusrca = 1'b1; alusrcb = 2'b10; state_nxt = ADDIWB; end
      ADDIWB:   regwrite = 1'b1;
      JUMP:     begin pcsrc = 2'b10; pcwrite = 1'b1; end
      default:  state_nxt = FETCH;
    endcase
  end
  // Non-Moore outputs: branch-qualified PC enable and the decode-time illegal flag.
  always_comb begin
    legal      = op inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
    pcen       = pcwrite | (branch & zero);
    illegal_op = state == DECODE && !legal;
    dbg_state  = STATE_W'(state);
  end
  mc_alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed instruction sequences checked against a table-driven model
module tb_mc_control_fsm;
  logic clk = 1'b0, reset_n = 1'b0, zero = 1'b0;
  logic [5:0] op = 6'd0, funct = 6'd0;
  logic pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] dbg_state;
  int errors = 0, checks = 0;
  int exp_q[$];

  mc_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .iord(iord), .memtoreg(memtoreg),
    .regdst(regdst), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .illegal_op(illegal_op), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] funct_ctl(input logic [5:0] f);
    case (f)
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  // Expected outputs derived signal by signal from the set of states in which each is active.
  function automatic logic [15:0] model(input int s, input logic [5:0] o, input logic [5:0] f, input logic z);
    logic pw, br, legal;
    logic [1:0] srcb, psel;
    logic [2:0] ctl;
    pw    = s inside {0, 11};
    br    = s == 8;
    legal = o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    srcb  = s == 0 ? 2'b01 : s == 1 ? 2'b11 : s inside {2, 9} ? 2'b10 : 2'b00;
    psel  = s == 8 ? 2'b01 : s == 11 ? 2'b10 : 2'b00;
    ctl   = s == 8 ? 3'b110 : s == 6 ? funct_ctl(f) : 3'b010;
    return {pw | (br & z), 1'(s == 5), 1'(s == 0), 1'(s inside {4, 7, 10}),
            1'(s inside {2, 6, 8, 9}), srcb, 1'(s inside {3, 5}), 1'(s == 4),
            1'(s == 7), psel, ctl, 1'(s == 1 && !legal)};
  endfunction

  // Compare process: one expected state per cycle from the queue, checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      int s;
      s = exp_q.pop_front();
      chk($sformatf("state op=%b f=%b", op, funct), dbg_state, s);
      chk($sformatf("outs s=%0d op=%b", s, op),
          {pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, iord, memtoreg,
           regdst, pcsrc, alucontrol, illegal_op}, model(s, op, funct, zero));
    end
  end

  // Queue the state trace an opcode must walk, then let it run to the next FETCH.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
    int n;
    op = o; funct = f; zero = z;
    exp_q.push_back(0);
    exp_q.push_back(1);
    case (o)
      6'b100011: begin exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4); end
      6'b101011: begin exp_q.push_back(2); exp_q.push_back(5); end
      6'b000000: begin exp_q.push_back(6); exp_q.push_back(7); end
      6'b000100: exp_q.push_back(8);
      6'b001000: begin exp_q.push_back(9); exp_q.push_back(10); end
      6'b000010: exp_q.push_back(11);
      default: ;
    endcase
    n = exp_q.size();
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst state", dbg_state, 0);
    chk("rst irwrite", irwrite, 1);
    chk("rst pcen", pcen, 1);
    chk("rst alusrcb", alusrcb, 2'b01);
    chk("rst alucontrol", alucontrol, 3'b010);
    chk("rst regwrite", regwrite, 0);
    reset_n = 1'b1;
    run_instr(6'b100011, 6'd0, 1'b0);
    run_instr(6'b101011, 6'd0, 1'b0);
    run_instr(6'b001000, 6'd0, 1'b0);
    run_instr(6'b000000, 6'h20, 1'b0);
    run_instr(6'b000000, 6'h22, 1'b0);
    run_instr(6'b000000, 6'h24, 1'b0);
    run_instr(6'b000000, 6'h25, 1'b0);
    run_instr(6'b000000, 6'h2A, 1'b0);
    run_instr(6'b000000, 6'h27, 1'b0);
    run_instr(6'b000100, 6'd0, 1'b1);
    run_instr(6'b000100, 6'd0, 1'b0);
    run_instr(6'b000010, 6'd0, 1'b0);
    run_instr(6'b111111, 6'd0, 1'b0);
    run_instr(6'b000011, 6'd0, 1'b0);
    // beq with zero toggled inside the BRANCH cycle
    op = 6'b000100; zero = 1'b1;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(8);
    repeat (2) @(posedge clk);
    #1;
    chk("beq state", dbg_state, 8);
    chk("beq pcen z1", pcen, 1);
    chk("beq pcsrc", pcsrc, 2'b01);
    chk("beq alucontrol", alucontrol, 3'b110);
    zero = 1'b0;
    #1 chk("beq pcen z0", pcen, 0);
    zero = 1'b1;
    @(posedge clk);
    #1;
    // j literal pin
    op = 6'b000010;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(11);
    repeat (2) @(posedge clk);
    #1;
    chk("j pcen", pcen, 1);
    chk("j pcsrc", pcsrc, 2'b10);
    @(posedge clk);
    #1;
    // illegal literal pin
    op = 6'b111111;
    exp_q.push_back(0); exp_q.push_back(1);
    @(posedge clk);
    #1;
    chk("ill flag", illegal_op, 1);
    chk("ill regwrite", regwrite, 0);
    @(posedge clk);
    #1;
    chk("ill next", dbg_state, 0);
    chk("ill flag clr", illegal_op, 0);
    // reset asserted while in MEMRD takes effect without a clock edge
    op = 6'b100011;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    repeat (3) @(posedge clk);
    #1;
    chk("memrd state", dbg_state, 3);
    chk("memrd iord", iord, 1);
    reset_n = 1'b0;
    #1;
    chk("async rst state", dbg_state, 0);
    chk("async rst irwrite", irwrite, 1);
    chk("async rst iord", iord, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_instr(6'b001000, 6'd0, 1'b0);
    run_instr(6'b100011, 6'd0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle MIPS main controller that sits directly upstream of the 32-bit ALU and the multicycle datapath.
- Decodes opcode/funct of the instruction register and steps a Moore FSM through fetch/decode/execute/memory/writeback.
- Drives the ALU 3-bit alucontrol, the operand selects and every datapath enable; consumes the ALU zero flag for beq.
- Exposes the state register for the debug build.

Parameters:
- STATE_W, 4, width of the state register and of dbg_state.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- op  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU zero flag
- pcen  out  1  PC register enable
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU operand A select: 0=PC, 1=A register
- alusrcb  out  2  ALU operand B select: 00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- memtoreg  out  1  register writeback select: 0=ALUOut, 1=Data
- regdst  out  1  destination register select: 0=rt, 1=rd
- pcsrc  out  2  next-PC select: 00=ALUResult, 01=ALUOut, 10=jump target
- alucontrol  out  3  to ALU: 010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal_op  out  1  high while in DECODE with an unsupported op
- dbg_state  out  STATE_W  current state encoding

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (reset_n); asserting it forces state=FETCH immediately, including in the middle of an instruction.
- Output timing: all outputs are combinational from state (Moore), except pcen = pcwrite | (branch & zero) and illegal_op.
- Outputs during and after reset are the FETCH values: irwrite=1, pcen=1, alusrcb=01, alucontrol=010, all other outputs 0.
- State encoding and per-state outputs. Unlisted outputs are 0; pcsrc=00; alusrcb=00. aluop is internal.
  - FETCH=0: iord=0, alusrca=0, alusrcb=01, aluop=00, irwrite=1, pcwrite=1
  - DECODE=1: alusrca=0, alusrcb=11, aluop=00
  - MEMADR=2: alusrca=1, alusrcb=10, aluop=00
  - MEMRD=3: iord=1
  - MEMWB=4: regwrite=1, memtoreg=1
  - MEMWR=5: iord=1, memwrite=1
  - EXECUTE=6: alusrca=1, aluop=10
  - ALUWB=7: regdst=1, regwrite=1
  - BRANCH=8: alusrca=1, aluop=01, pcsrc=01, branch=1
  - ADDIEXEC=9: alusrca=1, alusrcb=10, aluop=00
  - ADDIWB=10: regwrite=1
  - JUMP=11: pcsrc=10, pcwrite=1
  - Codes 12-15 are unused; they transition to FETCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE on op: 100011 (lw) or 101011 (sw) -> MEMADR; 000000 (R-type) -> EXECUTE; 000100 (beq) -> BRANCH; 001000 (addi) -> ADDIEXEC; 000010 (j) -> JUMP; any other op -> FETCH with illegal_op=1 for that cycle.
  - MEMADR -> MEMRD if op=lw, otherwise MEMWR.
  - MEMRD -> MEMWB.
  - EXECUTE -> ALUWB.
  - ADDIEXEC -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB and JUMP all -> FETCH.
- Latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- ALU decode (aluop, funct -> alucontrol):
  - aluop 00 -> 010; aluop 01 -> 110; aluop 11 -> 010.
  - aluop 10 with funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; any other funct -> 010 (no trap).
- beq: pcen is high in BRANCH only when zero=1. A zero change mid-cycle propagates combinationally.

Decomposition:
- Shared package mips_ctrl_pkg:
  - state localparams FETCH..JUMP
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - funct constants
  - ALUCTL_ADD/SUB/AND/OR/SLT
- One sub-module, mc_alu_decoder: combinational (aluop, funct) -> alucontrol. It is reused by the single-cycle core.

Test Plan:
- Reset: hold reset_n=0, then release -> dbg_state=0, irwrite=1, pcen=1, alusrcb=01, alucontrol=010. Re-assert reset_n while in MEMRD -> dbg_state=0 immediately, with no clock edge needed.
- lw: op=100011 -> dbg_state sequence 0,1,2,3,4,0. MEMRD has iord=1. MEMWB has regwrite=1, memtoreg=1, regdst=0.
- sw and addi:
  - sw: sequence 0,1,2,5,0, with memwrite=1 only in state 5.
  - addi (op=001000): sequence 0,1,9,10,0, with alusrcb=10 in state 9 and regwrite=1 in state 10.
- R-type: op=0 with each funct 20h/22h/24h/25h/2Ah -> alucontrol in EXECUTE = 010/110/000/001/111. ALUWB has regdst=1, regwrite=1.
- beq: op=000100 with zero=1 -> pcen=1, pcsrc=01, alucontrol=110 in state 8. With zero=0 -> pcen=0.
- j and illegal:
  - j: state 11 has pcen=1, pcsrc=10.
  - illegal: op=111111 -> illegal_op=1 in DECODE only, next state 0, regwrite/memwrite never asserted.
